// File: rtl/mem_pkg.sv
// Shared types for the memory controller: FSM state encoding and error read-back word.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    localparam logic [31:0] MEM_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_ctrl.sv
// Bridges single-cycle CPU memory strobes onto a req/ack external memory port.
// Optional ack timeout with bus error is enabled by defining MEM_CTRL_TIMEOUT_EN.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_rd,
    input  logic                  mem_wr,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output tri   [31:0]           rdata,
    output logic                  stall,
    output logic                  ext_req,
    output logic                  ext_we,
    output logic [ADDR_WIDTH-1:0] ext_addr,
    output logic [31:0]           ext_wdata,
    input  logic                  ext_ack,
    input  logic [31:0]           ext_rdata,
    output logic                  bus_err
);

    mem_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           data_q, data_d;
    logic                  we_q, we_d;
    logic                  stall_raw;

`ifdef MEM_CTRL_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             expired;

    // Expiry is the TIMEOUT-th REQ cycle without ack; an ack in that cycle wins.
    assign expired = (state_q == REQ) && !ext_ack && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign bus_err = err_q;
`else
    localparam int unsigned unused_timeout = TIMEOUT;
    assign bus_err = 1'b0;
`endif

    // Upper address bits wrap silently.
    logic unused_addr;
    assign unused_addr = ^addr;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        data_d    = data_q;
        we_d      = we_q;
        stall_raw = 1'b0;
`ifdef MEM_CTRL_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                stall_raw = mem_rd | mem_wr;
                if (mem_rd | mem_wr) begin
                    addr_d  = addr[ADDR_WIDTH-1:0];
                    wdata_d = wdata;
                    we_d    = mem_wr & ~mem_rd;
                    state_d = REQ;
`ifdef MEM_CTRL_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            REQ: begin
                stall_raw = 1'b1;
                if (ext_ack) begin
                    if (!we_q) data_d = ext_rdata;
                    state_d = DONE;
`ifdef MEM_CTRL_TIMEOUT_EN
                end else if (expired) begin
                    if (!we_q) data_d = MEM_ERR_DATA;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
`ifdef MEM_CTRL_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            we_q    <= we_d;
`ifdef MEM_CTRL_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // Stall is held low while reset is asserted, even with strobes high.
    assign stall     = stall_raw & ~rst;
    assign ext_req   = (state_q == REQ);
    assign ext_we    = we_q;
    assign ext_addr  = addr_q;
    assign ext_wdata = wdata_q;
    assign rdata     = ((state_q == DONE) && !we_q) ? data_q : {32{1'bz}};

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed-vector bench for mem_ctrl; define MEM_CTRL_TIMEOUT_EN to also exercise the ack timeout.
module tb_mem_ctrl;

    localparam logic [31:0] ZVAL = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rd, mem_wr;
    logic [31:0] addr, wdata;
    wire  [31:0] rdata;
    logic        stall, ext_req, ext_we;
    logic [15:0] ext_addr;
    logic [31:0] ext_wdata;
    logic        ext_ack;
    logic [31:0] ext_rdata;
    logic        bus_err;

    int n_vec = 0;
    int n_err = 0;

    // An undriven result bus floats to all ones.
    pullup (rdata);

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_WIDTH(16), .TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .ext_req   (ext_req),
        .ext_we    (ext_we),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .ext_ack   (ext_ack),
        .ext_rdata (ext_rdata),
        .bus_err   (bus_err)
    );

    always @(posedge clk)
        if (!rst && mem_rd && mem_wr)
            $display("protocol violation: mem_rd and mem_wr both high at %0t", $time);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Read with `waits` ack-less REQ cycles before the ack; `both` also raises mem_wr.
    task automatic rd_xact(input logic [31:0] a, input logic [31:0] d, input int waits,
                           input logic both, input string tag);
        @(negedge clk);
        mem_rd = 1'b1; mem_wr = both; addr = a; wdata = 32'h0000_AAAA;
        #1 chk({tag, " stall c0"}, 32'(stall), 32'd1);
        for (int i = 0; i <= waits; i++) begin
            @(negedge clk);
            mem_rd = 1'b0; mem_wr = 1'b0;
            ext_ack   = (i == waits);
            ext_rdata = (i == waits) ? d : ~d;
            #1;
            chk({tag, " ext_req"},  32'(ext_req),  32'd1);
            chk({tag, " ext_we"},   32'(ext_we),   32'd0);
            chk({tag, " ext_addr"}, 32'(ext_addr), {16'h0, a[15:0]});
            chk({tag, " stall req"}, 32'(stall),   32'd1);
            chk({tag, " rdata req"}, rdata,        ZVAL);
        end
        @(negedge clk);
        ext_ack = 1'b0;
        #1;
        chk({tag, " rdata done"}, rdata,          d);
        chk({tag, " stall done"}, 32'(stall),     32'd0);
        chk({tag, " req done"},   32'(ext_req),   32'd0);
        chk({tag, " bus_err"},    32'(bus_err),   32'd0);
        @(negedge clk);
        #1 chk({tag, " rdata idle"}, rdata, ZVAL);
    endtask

    initial begin
        rst = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; addr = 32'h0000_1234; wdata = '0;
        ext_ack = 1'b0; ext_rdata = '0;

        // Reset held two cycles with a read strobe high.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            chk("rst stall",   32'(stall),   32'd0);
            chk("rst ext_req", 32'(ext_req), 32'd0);
            chk("rst rdata",   rdata,        ZVAL);
            chk("rst ext_we",  32'(ext_we),  32'd0);
            chk("rst bus_err", 32'(bus_err), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0; mem_rd = 1'b0;

        rd_xact(32'h0001_0042, 32'hCAFE_F00D, 0, 1'b0, "rd0");

        // Write with three waited REQ cycles; wdata bus changes but ext_wdata must hold.
        @(negedge clk);
        mem_wr = 1'b1; addr = 32'd5; wdata = 32'h1234_5678;
        #1 chk("wr stall c0", 32'(stall), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_wr = 1'b0; wdata = 32'hFFFF_0000; addr = 32'd9;
            ext_ack = (i == 3); ext_rdata = 32'h5555_5555;
            #1;
            chk("wr ext_req",   32'(ext_req),   32'd1);
            chk("wr ext_we",    32'(ext_we),    32'd1);
            chk("wr ext_wdata", ext_wdata,      32'h1234_5678);
            chk("wr ext_addr",  32'(ext_addr),  32'd5);
            chk("wr rdata",     rdata,          ZVAL);
        end
        @(negedge clk);
        ext_ack = 1'b0;
        #1;
        chk("wr done stall", 32'(stall),   32'd0);
        chk("wr done req",   32'(ext_req), 32'd0);
        chk("wr done rdata", rdata,        ZVAL);

        rd_xact(32'h0000_0077, 32'h1111_2222, 0, 1'b1, "both");

        // Spurious ack while idle.
        @(negedge clk);
        ext_ack = 1'b1; ext_rdata = 32'h9999_9999;
        @(negedge clk);
        ext_ack = 1'b0;
        #1;
        chk("spur req",   32'(ext_req), 32'd0);
        chk("spur stall", 32'(stall),   32'd0);
        chk("spur rdata", rdata,        ZVAL);

        // Reset during the second REQ cycle abandons the access.
        @(negedge clk);
        mem_rd = 1'b1; addr = 32'h0000_0010;
        @(negedge clk);
        mem_rd = 1'b0;
        #1 chk("mid req c1", 32'(ext_req), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("mid rst stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid post req",   32'(ext_req), 32'd0);
        chk("mid post stall", 32'(stall),   32'd0);
        chk("mid post rdata", rdata,        ZVAL);
        rd_xact(32'h0003_0099, 32'h0BAD_F00D, 1, 1'b0, "after");

`ifdef MEM_CTRL_TIMEOUT_EN
        // Four REQ cycles with no ack expire into an error read.
        @(negedge clk);
        mem_rd = 1'b1; addr = 32'h0000_0020;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_rd = 1'b0; ext_ack = 1'b0;
            #1;
            chk("to ext_req", 32'(ext_req), 32'd1);
            chk("to bus_err", 32'(bus_err), 32'd0);
        end
        @(negedge clk);
        #1;
        chk("to err pulse", 32'(bus_err), 32'd1);
        chk("to err data",  rdata,        32'hDEAD_BEEF);
        chk("to err req",   32'(ext_req), 32'd0);
        @(negedge clk);
        #1;
        chk("to err clr",   32'(bus_err), 32'd0);
        chk("to err rdata", rdata,        ZVAL);
        rd_xact(32'h0000_0021, 32'hA5A5_0F0F, 3, 1'b0, "to ack");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
